// File: rtl/quad_encoder_emulator.sv
// Avalon-MM quadrature encoder waveform generator with signed position tracking.
// Optional burst-done interrupt output is enabled by defining QENC_IRQ_EN.
//
// state | meaning
// P00   | A=0 B=0
// P01   | A=0 B=1
// P11   | A=1 B=1
// P10   | A=1 B=0
module quad_encoder_emulator #(
    parameter int QPERIOD_W = 16,
    parameter int BURST_W   = 16
) (
    input  logic        clk_clk,
    input  logic        rst_reset_n,
    input  logic [1:0]  avalon_slave_address,
    input  logic [31:0] avalon_slave_writedata,
    output logic [31:0] avalon_slave_readdata,
    input  logic        avalon_slave_write,
    input  logic        avalon_slave_read,
    output logic [1:0]  encoded_out
`ifdef QENC_IRQ_EN
    ,
    output logic        irq
`endif
);

    // Encoding equals the {A,B} levels so the state register drives the pins directly.
    typedef enum logic [1:0] {
        P00 = 2'b00,
        P01 = 2'b01,
        P11 = 2'b11,
        P10 = 2'b10
    } phase_t;

    phase_t               state_q, state_d;
    logic                 en_q, en_d;
    logic                 dir_q, dir_d;
    logic                 burst_q, burst_d;
    logic                 done_q, done_d;
    logic                 irq_en_q, irq_en_d;
    logic                 irq_q, irq_d;
    logic [QPERIOD_W-1:0] qperiod_q, qperiod_d;
    logic [QPERIOD_W-1:0] timer_q, timer_d;
    logic [BURST_W-1:0]   burst_len_q, burst_len_d;
    logic [BURST_W-1:0]   remaining_q, remaining_d;
    logic [31:0]          position_q, position_d;

    logic   wr_ctrl, wr_qperiod, wr_burst;
    logic   running, step, a_rise, burst_end;
    phase_t phase_ccw, phase_cw;

    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            state_q     <= P00;
            en_q        <= 1'b0;
            dir_q       <= 1'b0;
            burst_q     <= 1'b0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            qperiod_q   <= '0;
            timer_q     <= '0;
            burst_len_q <= '0;
            remaining_q <= '0;
            position_q  <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            dir_q       <= dir_d;
            burst_q     <= burst_d;
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            qperiod_q   <= qperiod_d;
            timer_q     <= timer_d;
            burst_len_q <= burst_len_d;
            remaining_q <= remaining_d;
            position_q  <= position_d;
        end
    end

    always_comb begin
        wr_ctrl    = avalon_slave_write && (avalon_slave_address == 2'd0);
        wr_qperiod = avalon_slave_write && (avalon_slave_address == 2'd1);
        wr_burst   = avalon_slave_write && (avalon_slave_address == 2'd2);

        running = en_q && (qperiod_q != '0) && !(burst_q && (remaining_q == '0));
        // Compare against the live period so a shrink below the current count steps at once.
        step    = running && (timer_q >= (qperiod_q - QPERIOD_W'(1)));

        timer_d = '0;
        if (running && !step) begin
            timer_d = timer_q + QPERIOD_W'(1);
        end

        phase_ccw = P00;
        phase_cw  = P00;
        case (state_q)
            P00: begin phase_ccw = P01; phase_cw = P10; end
            P01: begin phase_ccw = P11; phase_cw = P00; end
            P11: begin phase_ccw = P10; phase_cw = P01; end
            P10: begin phase_ccw = P00; phase_cw = P11; end
            default: begin phase_ccw = P00; phase_cw = P00; end
        endcase

        state_d = state_q;
        if (step) begin
            state_d = dir_q ? phase_ccw : phase_cw;
        end
        a_rise    = step && !state_q[1] && state_d[1];
        burst_end = a_rise && burst_q && (remaining_q == BURST_W'(1));

        en_d     = en_q;
        dir_d    = dir_q;
        burst_d  = burst_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            en_d    = avalon_slave_writedata[0];
            dir_d   = avalon_slave_writedata[1];
            burst_d = avalon_slave_writedata[2];
`ifdef QENC_IRQ_EN
            irq_en_d = avalon_slave_writedata[6];
`endif
        end
        if (burst_end) begin
            en_d = 1'b0;
        end

        done_d = done_q;
        if (wr_ctrl && avalon_slave_writedata[4]) begin
            done_d = 1'b0;
        end
        if (burst_end) begin
            done_d = 1'b1;
        end
        irq_d = done_q && irq_en_q;

        qperiod_d = qperiod_q;
        if (wr_qperiod) begin
            qperiod_d = avalon_slave_writedata[QPERIOD_W-1:0];
        end

        burst_len_d = burst_len_q;
        remaining_d = remaining_q;
        if (a_rise && burst_q && (remaining_q != '0)) begin
            remaining_d = remaining_q - BURST_W'(1);
        end
        if (wr_burst) begin
            burst_len_d = avalon_slave_writedata[BURST_W-1:0];
            remaining_d = avalon_slave_writedata[BURST_W-1:0];
        end

        position_d = position_q;
        if (a_rise) begin
            position_d = dir_q ? (position_q + 32'd1) : (position_q - 32'd1);
        end
        if (wr_ctrl && avalon_slave_writedata[3]) begin
            position_d = '0;
        end
    end

    always_comb begin
        avalon_slave_readdata = '0;
        case (avalon_slave_address)
            2'd0: avalon_slave_readdata = {25'd0, irq_en_q, running, done_q, 1'b0,
                                           burst_q, dir_q, en_q};
            2'd1: avalon_slave_readdata = 32'(qperiod_q);
            2'd2: avalon_slave_readdata = 32'(burst_len_q);
            2'd3: avalon_slave_readdata = position_q;
            default: avalon_slave_readdata = '0;
        endcase
    end

    assign encoded_out = state_q;
`ifdef QENC_IRQ_EN
    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Randomized self-checking bench for quad_encoder_emulator against a phase-index/step-count model.
// Defining QENC_IRQ_EN also exercises the interrupt output.
module tb_quad_encoder_emulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        write_s;
    logic        read_s;
    logic [1:0]  enc;
`ifdef QENC_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    quad_encoder_emulator dut (
        .clk_clk               (clk),
        .rst_reset_n           (rst_n),
        .avalon_slave_address  (addr),
        .avalon_slave_writedata(wdata),
        .avalon_slave_readdata (rdata),
        .avalon_slave_write    (write_s),
        .avalon_slave_read     (read_s),
        .encoded_out           (enc)
`ifdef QENC_IRQ_EN
        ,
        .irq                   (irq)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  gray [4];
    int          midx;
    logic [31:0] mpos;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int next_idx(input int dir);
        return dir != 0 ? (midx + 1) % 4 : (midx + 3) % 4;
    endfunction

    function automatic bit is_rise(input int dir);
        return !gray[midx][1] && gray[next_idx(dir)][1];
    endfunction

    function automatic void model_step(input int dir);
        if (is_rise(dir)) mpos = (dir != 0) ? mpos + 32'd1 : mpos - 32'd1;
        midx = next_idx(dir);
    endfunction

    task automatic drive_wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; write_s = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive_wr(a, d);
        @(negedge clk);
        write_s = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a; read_s = 1'b1;
        #1;
        d = rdata;
        read_s = 1'b0;
    endtask

    // Free run of `cycles` edges after EN; optional direction flip and a CLR_POS placed on an A-rise step.
    task automatic run_seg(input int n, input int dir0, input int cycles, input int flip_edge,
                           input bit want_clr);
        int          mdir;
        bit          clr_pending;
        bit          clr_now;
        logic [1:0]  prev;
        logic [31:0] r;
        mdir        = dir0;
        clr_pending = want_clr;
        clr_now     = 1'b0;
        wr(2'd1, 32'(n));
        prev = enc;
        drive_wr(2'd0, 32'(1 | (mdir << 1)));
        for (int e = 0; e <= cycles + 4; e++) begin
            @(negedge clk);
            write_s = 1'b0;
            if (e > 0 && e <= cycles + 1 && e % n == 0) model_step(mdir);
            if (clr_now) begin mpos = '0; clr_now = 1'b0; end
            if (e == flip_edge) mdir = 1 - mdir;
            chk("wave", {30'd0, enc}, {30'd0, gray[midx]});
            chk("one_bit", {31'd0, (enc ^ prev) == 2'b11}, 32'd0);
            prev = enc;
            if (e + 1 == cycles + 1) drive_wr(2'd0, 32'd0);
            else if (e + 1 == flip_edge) drive_wr(2'd0, 32'(1 | ((1 - mdir) << 1)));
            else if (clr_pending && (e + 1) <= cycles && (e + 1) % n == 0 && is_rise(mdir)) begin
                drive_wr(2'd0, 32'(1 | (mdir << 1) | 8));
                clr_pending = 1'b0;
                clr_now     = 1'b1;
            end
        end
        if (want_clr) chk("clr_hit", {31'd0, clr_pending}, 32'd0);
        rd(2'd3, r);
        chk("seg_pos", r, mpos);
    endtask

    task automatic run_burst(input int n, input int dir, input int len);
        int          rises;
        int          seen;
        bit          fin;
        logic [1:0]  prev;
        logic [31:0] r;
        rises = 0; seen = 0; fin = 1'b0;
        wr(2'd1, 32'(n));
        wr(2'd2, 32'(len));
        prev = enc;
        drive_wr(2'd0, 32'(1 | (dir << 1) | 4));
        for (int e = 0; e <= 4 * n * len + 10; e++) begin
            @(negedge clk);
            write_s = 1'b0;
            if (!fin && e > 0 && e % n == 0) begin
                if (is_rise(dir)) rises++;
                model_step(dir);
                if (rises == len) fin = 1'b1;
            end
            chk("burst_wave", {30'd0, enc}, {30'd0, gray[midx]});
            if (!prev[1] && enc[1]) begin
                seen++;
                chk("b_at_rise", {31'd0, enc[0]}, 32'(dir));
            end
            prev = enc;
        end
        chk("burst_rises", 32'(seen), 32'(len));
        chk("burst_hold", {30'd0, enc}, (dir != 0) ? 32'd3 : 32'd2);
        rd(2'd0, r);
        chk("burst_ctrl", r, 32'(32'h14 | (dir << 1)));
        rd(2'd3, r);
        chk("burst_pos", r, mpos);
        wr(2'd0, 32'h10);
        rd(2'd0, r);
        chk("clr_done", r, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int          changes;
        int          s;
        bit          got_done;
        gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
        midx = 0; mpos = '0;
        rst_n = 1'b0; addr = '0; wdata = '0; write_s = 1'b0; read_s = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_enc", {30'd0, enc}, 32'd0);
        rd(2'd0, r); chk("rst_ctrl", r, 32'd0);
        rd(2'd1, r); chk("rst_qper", r, 32'd0);
        rd(2'd2, r); chk("rst_blen", r, 32'd0);
        rd(2'd3, r); chk("rst_pos", r, 32'd0);

        wr(2'd1, 32'd3);
        wr(2'd0, 32'h42);
        rd(2'd0, r);
`ifdef QENC_IRQ_EN
        chk("ctrl_bit6", r, 32'h42);
`else
        chk("ctrl_bit6", r, 32'h02);
`endif
        changes = 0;
        repeat (1000) begin
            @(negedge clk);
            if (enc != 2'b00) changes++;
        end
        chk("frozen_en0", 32'(changes), 32'd0);
        rd(2'd1, r); chk("qper_rb", r, 32'd3);

        wr(2'd1, 32'd0);
        wr(2'd0, 32'd1);
        changes = 0;
        repeat (50) begin
            @(negedge clk);
            if (enc != 2'b00) changes++;
        end
        chk("frozen_qp0", 32'(changes), 32'd0);
        rd(2'd0, r); chk("ctrl_qp0", r, 32'd1);
        wr(2'd0, 32'd0);

        run_seg(5, 1, 200, -1, 1'b0);
        rd(2'd3, r); chk("pos_plus10", r, 32'd10);

        wr(2'd0, 32'h08);
        mpos = '0;
        run_burst(3, 0, 4);
        rd(2'd3, r); chk("pos_minus4", r, 32'hFFFF_FFFC);

        for (int t = 0; t < 6; t++) begin
            int n, c, fe;
            n  = $urandom_range(1, 6);
            c  = $urandom_range(20, 80);
            fe = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, c - 1)) : -1;
            run_seg(n, int'($urandom_range(0, 1)), c, fe, 1'b0);
        end

        run_seg(2, 1, 40, 17, 1'b0);
        run_seg(3, 1, 60, -1, 1'b1);

        for (int t = 0; t < 3; t++) begin
            run_burst($urandom_range(1, 4), $urandom_range(0, 1), $urandom_range(1, 5));
        end

        wr(2'd0, 32'h08);
        mpos = '0;
        run_burst(2, 0, 1);
        rd(2'd3, r); chk("pos_wrap", r, 32'hFFFF_FFFF);

        wr(2'd1, 32'd100);
        drive_wr(2'd0, 32'd3);
        for (int e = 0; e <= 55; e++) begin
            @(negedge clk);
            write_s = 1'b0;
            if (e == 52 || e == 53) model_step(1);
            if (e >= 1) chk("qp_shrink", {30'd0, enc}, {30'd0, gray[midx]});
            if (e == 50) drive_wr(2'd1, 32'd1);
            if (e == 52) drive_wr(2'd0, 32'd0);
        end
        rd(2'd3, r); chk("qp_shrink_pos", r, mpos);

        wr(2'd1, 32'd2);
        wr(2'd0, 32'd3);
        s = (midx == 1) ? 2 : 3;
        repeat (2 * s) @(negedge clk);
        for (int k = 0; k < s; k++) model_step(1);
        chk("pre_rst_enc", {30'd0, enc}, {30'd0, gray[midx]});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_enc", {30'd0, enc}, 32'd0);
        rd(2'd3, r); chk("async_rst_pos", r, 32'd0);
        rd(2'd0, r); chk("async_rst_ctrl", r, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        midx = 0; mpos = '0;
        repeat (20) @(negedge clk);
        chk("post_rst_enc", {30'd0, enc}, 32'd0);

`ifdef QENC_IRQ_EN
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h45);
        got_done = 1'b0;
        for (int k = 0; k < 20 && !got_done; k++) begin
            @(negedge clk);
            rd(2'd0, r);
            if (r[4]) begin
                got_done = 1'b1;
                chk("irq_lag", {31'd0, irq}, 32'd0);
                @(negedge clk);
                chk("irq_rise", {31'd0, irq}, 32'd1);
            end
        end
        chk("irq_done_seen", {31'd0, got_done}, 32'd1);
        wr(2'd0, 32'h50);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_drop", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'd4);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h05);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("irq_rst_enc", {30'd0, enc}, 32'd0);
        chk("irq_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`else
        got_done = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
